// File: rtl/prbs31_checker.sv
// prbs31_checker: serial PRBS31 (x^31 + x^28 + 1) receive checker.
// Seeds a local LFSR from the incoming stream, verifies the seed, then
// predicts every bit while locked, counting mismatches and dropping lock
// when too many errors land inside one observation window.
// Optional feature macro: PRBS31_CHK_BITCNT_EN adds the 32-bit bit_cnt port.
module prbs31_checker #(
   parameter int VERIFY_LEN  = 32,
   parameter int WIN_LEN     = 64,
   parameter int LOSS_THRESH = 8,
   parameter int ERR_CNT_W   = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 din,
   input  logic                 clr,
   output logic                 locked,
   output logic                 err_pulse,
   output logic                 lost_pulse,
   output logic [ERR_CNT_W-1:0] err_cnt
`ifdef PRBS31_CHK_BITCNT_EN
   ,
   output logic [31:0]          bit_cnt
`endif
);

   localparam int VCNT_W = (VERIFY_LEN > 1)  ? $clog2(VERIFY_LEN)  : 1;
   localparam int WCNT_W = (WIN_LEN > 1)     ? $clog2(WIN_LEN)     : 1;
   localparam int WERR_W = (LOSS_THRESH > 1) ? $clog2(LOSS_THRESH) : 1;

   localparam logic [VCNT_W-1:0] VER_LAST  = VCNT_W'(VERIFY_LEN - 1);
   localparam logic [WCNT_W-1:0] WIN_LAST  = WCNT_W'(WIN_LEN - 1);
   localparam logic [WERR_W-1:0] LOSS_LAST = WERR_W'(LOSS_THRESH - 1);
   localparam logic [4:0]        SEED_LAST = 5'd30;

   typedef enum logic [1:0] {
      ST_SEED   = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [30:0]           s_q, s_d;
   logic [4:0]            seed_cnt_q, seed_cnt_d;
   logic [VCNT_W-1:0]     ver_cnt_q, ver_cnt_d;
   logic [WCNT_W-1:0]     win_cnt_q, win_cnt_d;
   logic [WERR_W-1:0]     win_err_q, win_err_d;
   logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
   logic                  locked_q, locked_d;
   logic                  err_pulse_q, err_pulse_d;
   logic                  lost_pulse_q, lost_pulse_d;
`ifdef PRBS31_CHK_BITCNT_EN
   logic [31:0]           bit_cnt_q, bit_cnt_d;
`endif

   logic                  pred;
   logic                  miss;
   logic                  win_wrap;
   logic [30:0]           s_seed;
   logic [30:0]           s_free;
   logic [WERR_W-1:0]     win_base;

   // Next PRBS31 bit predicted from the last 31 bits (taps 31 and 28).
   function automatic logic prbs_pred(input logic [30:0] s);
      return s[30] ^ s[27];
   endfunction

   // Saturating increment: the all-ones value holds.
   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
      return (&v) ? v : v + ERR_CNT_W'(1);
   endfunction

   // Next-state, counters and pulses; nothing advances while en is low.
   always_comb begin
      state_d      = state_q;
      s_d          = s_q;
      seed_cnt_d   = seed_cnt_q;
      ver_cnt_d    = ver_cnt_q;
      win_cnt_d    = win_cnt_q;
      win_err_d    = win_err_q;
      err_cnt_d    = err_cnt_q;
      err_pulse_d  = 1'b0;
      lost_pulse_d = 1'b0;
`ifdef PRBS31_CHK_BITCNT_EN
      bit_cnt_d    = bit_cnt_q;
`endif
      pred     = prbs_pred(s_q);
      miss     = din ^ pred;
      s_seed   = {s_q[29:0], din};
      s_free   = {s_q[29:0], pred};
      win_wrap = (win_cnt_q == WIN_LAST);
      // A mismatch on the wrap bit is charged to the window that starts there.
      win_base = win_wrap ? '0 : win_err_q;

      if (en) begin
         case (state_q)
            ST_SEED: begin
               s_d = s_seed;
               if (seed_cnt_q == SEED_LAST) begin
                  seed_cnt_d = '0;
                  // An all-zero seed is the LFSR lock-up state; keep seeding.
                  if (s_seed != '0) begin
                     state_d   = ST_VERIFY;
                     ver_cnt_d = '0;
                  end
               end else begin
                  seed_cnt_d = seed_cnt_q + 5'd1;
               end
            end
            ST_VERIFY: begin
               s_d = s_free;
               if (miss) begin
                  state_d    = ST_SEED;
                  seed_cnt_d = '0;
               end else if (ver_cnt_q == VER_LAST) begin
                  state_d   = ST_LOCKED;
                  ver_cnt_d = '0;
                  win_cnt_d = '0;
                  win_err_d = '0;
               end else begin
                  ver_cnt_d = ver_cnt_q + VCNT_W'(1);
               end
            end
            ST_LOCKED: begin
               // Free-running prediction: received errors never enter s.
               s_d       = s_free;
               win_cnt_d = win_wrap ? '0 : win_cnt_q + WCNT_W'(1);
               win_err_d = win_base;
`ifdef PRBS31_CHK_BITCNT_EN
               bit_cnt_d = bit_cnt_q + 32'd1;
`endif
               if (miss) begin
                  err_pulse_d = 1'b1;
                  err_cnt_d   = sat_inc(err_cnt_q);
                  if (win_base == LOSS_LAST) begin
                     lost_pulse_d = 1'b1;
                     state_d      = ST_SEED;
                     seed_cnt_d   = '0;
                     win_cnt_d    = '0;
                     win_err_d    = '0;
                  end else begin
                     win_err_d = win_base + WERR_W'(1);
                  end
               end
            end
            default: begin
               state_d    = ST_SEED;
               seed_cnt_d = '0;
            end
         endcase
      end

      // clr is a host command and acts even on idle cycles; it beats any increment.
      if (clr) begin
         err_cnt_d = '0;
`ifdef PRBS31_CHK_BITCNT_EN
         bit_cnt_d = '0;
`endif
      end

      locked_d = (state_d == ST_LOCKED);
   end

   // State and counter registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q      <= ST_SEED;
         s_q          <= '0;
         seed_cnt_q   <= '0;
         ver_cnt_q    <= '0;
         win_cnt_q    <= '0;
         win_err_q    <= '0;
         err_cnt_q    <= '0;
         locked_q     <= 1'b0;
         err_pulse_q  <= 1'b0;
         lost_pulse_q <= 1'b0;
`ifdef PRBS31_CHK_BITCNT_EN
         bit_cnt_q    <= '0;
`endif
      end else begin
         state_q      <= state_d;
         s_q          <= s_d;
         seed_cnt_q   <= seed_cnt_d;
         ver_cnt_q    <= ver_cnt_d;
         win_cnt_q    <= win_cnt_d;
         win_err_q    <= win_err_d;
         err_cnt_q    <= err_cnt_d;
         locked_q     <= locked_d;
         err_pulse_q  <= err_pulse_d;
         lost_pulse_q <= lost_pulse_d;
`ifdef PRBS31_CHK_BITCNT_EN
         bit_cnt_q    <= bit_cnt_d;
`endif
      end
   end

   assign locked     = locked_q;
   assign err_pulse  = err_pulse_q;
   assign lost_pulse = lost_pulse_q;
   assign err_cnt    = err_cnt_q;
`ifdef PRBS31_CHK_BITCNT_EN
   assign bit_cnt    = bit_cnt_q;
`endif

endmodule

// File: tb/tb_prbs31_checker.sv
// tb_prbs31_checker: directed bench for prbs31_checker with a reference
// PRBS31 generator (seed 31'b1) feeding din. A second instance with a
// 4-bit error counter exercises counter saturation in few cycles.
module tb_prbs31_checker;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic        en    = 1'b0;
   logic        din   = 1'b0;
   logic        clr   = 1'b0;
   logic        clr2  = 1'b0;
   logic        locked, err_pulse, lost_pulse;
   logic [15:0] err_cnt;
   logic        locked2, err_pulse2, lost_pulse2;
   logic [3:0]  err_cnt2;
`ifdef PRBS31_CHK_BITCNT_EN
   logic [31:0] bit_cnt;
   logic [31:0] bit_cnt2;
`endif

   int          checks   = 0;
   int          failures = 0;
   logic [30:0] g;
   int          n_err_p;
   int          n_lost_p;
   int          nlocked;
   int          nvalid;

   prbs31_checker dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .din        (din),
      .clr        (clr),
      .locked     (locked),
      .err_pulse  (err_pulse),
      .lost_pulse (lost_pulse),
      .err_cnt    (err_cnt)
`ifdef PRBS31_CHK_BITCNT_EN
      ,
      .bit_cnt    (bit_cnt)
`endif
   );

   prbs31_checker #(.ERR_CNT_W(4)) dut2 (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .din        (din),
      .clr        (clr2),
      .locked     (locked2),
      .err_pulse  (err_pulse2),
      .lost_pulse (lost_pulse2),
      .err_cnt    (err_cnt2)
`ifdef PRBS31_CHK_BITCNT_EN
      ,
      .bit_cnt    (bit_cnt2)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic gen_bit(input logic [30:0] v);
      return v[30] ^ v[27];
   endfunction

   // One clock: drive en/din/clr, wait the edge, sample 1 time unit later.
   task automatic step(input logic e, input logic flip, input logic c, input logic c2);
      logic was_locked;
      was_locked = locked;
      en   = e;
      clr  = c;
      clr2 = c2;
      din  = e ? (gen_bit(g) ^ flip) : ~g[0];
      @(posedge clk);
      #1;
      if (e) begin
         g = {g[29:0], gen_bit(g)};
         if (was_locked) nlocked++;
      end
      if (err_pulse)  n_err_p++;
      if (lost_pulse) n_lost_p++;
      clr  = 1'b0;
      clr2 = 1'b0;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      g = 31'd1;
      nlocked = 0;
   endtask

   task automatic lock_run(input string tag);
      repeat (62) step(1'b1, 1'b0, 1'b0, 1'b0);
      check({tag, "_pre"}, 32'(locked), 32'd0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check({tag, "_lock"}, 32'(locked), 32'd1);
      nlocked = 0;
   endtask

   initial begin
      g        = 31'd1;
      n_err_p  = 0;
      n_lost_p = 0;
      nlocked  = 0;
      nvalid   = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_locked",     32'(locked),     32'd0);
      check("rst_err_pulse",  32'(err_pulse),  32'd0);
      check("rst_lost_pulse", 32'(lost_pulse), 32'd0);
      check("rst_err_cnt",    32'(err_cnt),    32'd0);
      rst_n = 1'b0;

      // Clean stream locks after exactly 63 valid bits.
      lock_run("lock63");
      check("lock_err_cnt", 32'(err_cnt), 32'd0);

      n_err_p = 0;
      repeat (10000) step(1'b1, 1'b0, 1'b0, 1'b0);
      check("clean_err_pulses", 32'(n_err_p), 32'd0);
      check("clean_err_cnt",    32'(err_cnt), 32'd0);
      check("clean_locked",     32'(locked),  32'd1);
`ifdef PRBS31_CHK_BITCNT_EN
      check("clean_bit_cnt",    bit_cnt,      32'd10000);
`endif

      // Single flipped bit: one error, no multiplication, lock held.
      n_err_p = 0;
      step(1'b1, 1'b1, 1'b0, 1'b0);
      check("single_err_pulse",  32'(err_pulse),  32'd1);
      check("single_err_pulse2", 32'(err_pulse2), 32'd1);
      check("single_err_cnt",    32'(err_cnt),    32'd1);
      check("single_locked",     32'(locked),     32'd1);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check("single_next_clean", 32'(err_pulse),  32'd0);
      repeat (20) step(1'b1, 1'b0, 1'b0, 1'b0);
      check("single_pulse_count", 32'(n_err_p), 32'd1);
      check("single_err_cnt_hold", 32'(err_cnt), 32'd1);

      // clr on dut only.
      step(1'b1, 1'b0, 1'b1, 1'b0);
      check("clr_err_cnt",   32'(err_cnt),  32'd0);
      check("clr_other_dut", 32'(err_cnt2), 32'd1);

      // Move to the start of a fresh 64-bit window, then 8 errors in it.
      for (int i = 0; i < 64 && (nlocked % 64) != 0; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
      check("window_aligned", 32'(nlocked % 64), 32'd0);
      n_lost_p = 0;
      for (int k = 0; k < 8; k++) begin
         step(1'b1, 1'b1, 1'b0, 1'b0);
         if (k == 6) check("burst7_locked", 32'(locked), 32'd1);
         if (k < 7) step(1'b1, 1'b0, 1'b0, 1'b0);
      end
      check("burst_lost_pulse",  32'(lost_pulse),  32'd1);
      check("burst_lost_pulse2", 32'(lost_pulse2), 32'd1);
      check("burst_locked",      32'(locked),      32'd0);
      check("burst_err_cnt",     32'(err_cnt),     32'd8);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check("burst_lost_once",   32'(n_lost_p),    32'd1);
      check("burst_lost_low",    32'(lost_pulse),  32'd0);
      repeat (61) step(1'b1, 1'b0, 1'b0, 1'b0);
      check("relock_pre",  32'(locked), 32'd0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      check("relock_lock", 32'(locked), 32'd1);
      check("relock_err_cnt_kept", 32'(err_cnt),  32'd8);
      check("relock_err_cnt2",     32'(err_cnt2), 32'd9);

      // Saturation on the 4-bit counter: 9 -> 14, then 3 more hold at 15.
      for (int k = 0; k < 5; k++) begin
         step(1'b1, 1'b1, 1'b0, 1'b0);
         repeat (15) step(1'b1, 1'b0, 1'b0, 1'b0);
      end
      check("sat_at_e",      32'(err_cnt2), 32'hE);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      check("sat_reach_f",   32'(err_cnt2), 32'hF);
      repeat (15) step(1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
         step(1'b1, 1'b1, 1'b0, 1'b0);
         repeat (15) step(1'b1, 1'b0, 1'b0, 1'b0);
      end
      check("sat_hold_f",    32'(err_cnt2), 32'hF);
      check("sat_wide_cnt",  32'(err_cnt),  32'd16);
      check("sat_locked2",   32'(locked2),  32'd1);

      // clr together with an error: clear wins.
      step(1'b1, 1'b1, 1'b1, 1'b1);
      check("clr_err_pulse", 32'(err_pulse), 32'd1);
      check("clr_wins",      32'(err_cnt),   32'd0);
      check("clr_wins2",     32'(err_cnt2),  32'd0);

      // Five errors, then asynchronous reset mid-cycle.
      for (int k = 0; k < 5; k++) begin
         step(1'b1, 1'b1, 1'b0, 1'b0);
         repeat (15) step(1'b1, 1'b0, 1'b0, 1'b0);
      end
      check("pre_rst_err_cnt", 32'(err_cnt), 32'd5);
      check("pre_rst_locked",  32'(locked),  32'd1);
      rst_n = 1'b1;
      #2;
      check("async_locked",  32'(locked),  32'd0);
      check("async_err_cnt", 32'(err_cnt), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      g = 31'd1;
      nlocked = 0;
      lock_run("rst_relock");

      // din held at 0 never locks and never counts errors.
      pulse_reset();
      g = 31'd0;
      n_err_p = 0;
      repeat (200) step(1'b1, 1'b0, 1'b0, 1'b0);
      check("zero_locked",     32'(locked),  32'd0);
      check("zero_err_cnt",    32'(err_cnt), 32'd0);
      check("zero_err_pulses", 32'(n_err_p), 32'd0);

      // en dropped every third cycle: lock after 63 valid bits.
      pulse_reset();
      nvalid = 0;
      for (int cyc = 0; cyc < 200 && nvalid < 63; cyc++) begin
         logic e;
         e = ((cyc % 3) != 2);
         step(e, 1'b0, 1'b0, 1'b0);
         if (e) nvalid++;
         if (e && nvalid == 62) check("gap_pre", 32'(locked), 32'd0);
      end
      check("gap_valid_bits", 32'(nvalid), 32'd63);
      check("gap_lock",       32'(locked), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/prbs31_checker.md
# prbs31_checker

Serial PRBS31 receive checker (x^31 + x^28 + 1) that sits directly downstream of the team's PRBS31 generator and consumes its serial output bit. It self-synchronises by seeding a local LFSR from the incoming stream, then verifies the seed and declares lock. Once locked it predicts every bit, counts mismatches in a saturating counter, and drops lock when the error density exceeds a threshold. Results drive the tile's dedicated outputs for bench and bring-up observation.

## Interface
Parameters:
- VERIFY_LEN, 32: consecutive error-free bits required in VERIFY before LOCKED.
- WIN_LEN, 64: loss-of-lock observation window, in valid bits.
- LOSS_THRESH, 8: errors within one window that force loss of lock.
- ERR_CNT_W, 16: error counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-high (1 = reset).
- en  in  1  din valid this cycle; state advances only when en=1.
- din  in  1  received PRBS bit.
- clr  in  1  synchronous clear of err_cnt (and bit_cnt); lock state unaffected.
- locked  out  1  high in LOCKED state.
- err_pulse  out  1  one-cycle pulse: the compared bit mismatched.
- lost_pulse  out  1  one-cycle pulse: LOCKED→SEED due to threshold.
- err_cnt  out  ERR_CNT_W  saturating mismatch count.
- bit_cnt  out  32  compared-bit count (only with PRBS31_CHK_BITCNT_EN).

## Operation
- Local register s[30:0]; prediction p = s[30] ^ s[27]; shift is s <= {s[29:0], x}.
- States: SEED, VERIFY, LOCKED. Reset state SEED.
- SEED: x = din; seed counter counts valid bits 0..30. After the 31st valid bit: if s (including that bit) is nonzero → VERIFY; if all-zero → restart seed count, stay in SEED.
- VERIFY: x = p (free-run); compare din vs p. Mismatch → SEED, seed count 0; no err_pulse, no err_cnt change. VERIFY_LEN consecutive matches → LOCKED.
- LOCKED: x = p; mismatch → err_pulse, err_cnt+1 (saturate at all-ones, hold). Window counter counts valid bits mod WIN_LEN; window error count increments on mismatch. Window error count reaching LOSS_THRESH → lost_pulse, SEED, window counters cleared. Window wrap clears window error count (a mismatch on the wrap bit counts into the new window).
- Errors never propagate into s while locked (free-running prediction).
- clr and increment in the same cycle: clr wins, result 0.
- en=0: no state, counter or register change; pulses low.

## Timing
- All outputs registered; reset values: locked=0, err_pulse=0, lost_pulse=0, err_cnt=0, bit_cnt=0, s=0, state SEED.
- err_pulse/err_cnt update on the clock edge that samples the offending din (visible next cycle).
- locked rises on the edge sampling the VERIFY_LEN-th matching bit; minimum lock latency from reset release with en=1 continuous: 31 + VERIFY_LEN cycles.
- lost_pulse and locked fall on the same edge.
- Reset mid-operation: immediate async return to reset values; err_cnt is lost.

## Configuration
- PRBS31_CHK_BITCNT_EN defined: 32-bit bit_cnt increments on every compared valid bit in LOCKED, wraps at 2^32, cleared by clr (clr wins) and reset.
- Not defined: bit_cnt port and counter absent; all other behaviour identical.

## Test plan
- Clean PRBS31 from seed 31'b1, en=1 continuous -> locked=1 after exactly 63 cycles (defaults), err_cnt stays 0 for 10,000 bits.
- Locked, flip one bit -> single err_pulse, err_cnt=1, locked stays 1, next bits match (no error multiplication).
- Locked, flip 8 bits within one 64-bit window -> lost_pulse once, locked=0, relock 63 valid bits later; err_cnt=8 retained.
- din held 0 -> never leaves SEED/never locks, err_cnt=0; din toggling with en gaps (en=0 every 3rd cycle) -> lock after 63 valid bits.
- Force err_cnt to 16'hFFFE, inject 3 errors -> holds 16'hFFFF; assert clr with an error in same cycle -> err_cnt=0.
- rst_n pulsed while locked with err_cnt=5 -> all outputs 0 asynchronously, relock from SEED after release.
